link_token_credit_ctr: RTL and testbench

// - Upstream-link flow-control stage; sits directly downstream of the io_token pad input.
// - Converts returned token edges into send credits for the channel serializer (PISO/SSO).
// - Synchronises io_token into the io clock domain and counts both of its edges as credit returns.
// - Tracks words sent, asserts ready_o only when a credit exists, and flags protocol violations.

---
 rtl/link_token_credit_ctr.sv | 134 +++++++++++++
 tb/tb_link_token_credit_ctr.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/link_token_credit_ctr.sv
// link_token_credit_ctr
// Upstream-link flow-control stage. Synchronises the asynchronous io_token_i
// into the io clock domain and treats each token edge, rising or falling, as a
// return of 2^LG_DECIM credits. It counts words launched by the serializer and
// raises ready_o while at least one credit is held.
//
// Handshake: a word is transferred in a cycle where send_v_i && ready_o.
// ready_o is derived only from registered state. A send_v_i while ready_o is
// low is a protocol violation: the word is not counted and err_o is set.
//
// Optional build macro LINK_CREDIT_STALL_STATS_EN adds the stall_cnt_o and
// max_outstanding_o statistics outputs.
module link_token_credit_ctr #(
    parameter int CREDIT_MAX  = 32,
    parameter int LG_DECIM    = 3,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          io_token_i,
    input  logic                          send_v_i,
    output logic                          ready_o,
    output logic [$clog2(CREDIT_MAX):0]   credit_cnt_o,
    output logic [CNT_W-1:0]              sent_cnt_o,
    output logic [CNT_W-1:0]              finish_cnt_o,
`ifdef LINK_CREDIT_STALL_STATS_EN
    output logic [15:0]                   stall_cnt_o,
    output logic [$clog2(CREDIT_MAX):0]   max_outstanding_o,
`endif
    output logic                          err_o
);

    localparam int CW = $clog2(CREDIT_MAX) + 1;
    localparam int PW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW:0]   RET_VAL  = (CW+1)'(2 ** LG_DECIM);
    localparam logic [CW:0]   MAX_WIDE = (CW+1)'(CREDIT_MAX);
    localparam logic [CW-1:0] MAX_CRED = CW'(CREDIT_MAX);
    localparam logic [PW-1:0] PRIME_LAST = PW'(SYNC_STAGES);

    // PRIME masks edge detection until the synchroniser holds a settled value.
    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                 state;
    logic [PW-1:0]          prime_cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   edge_reg;
    logic                   tok_edge;
    logic [CW:0]            ret;
    logic                   use_credit;
    logic                   underflow;
    logic [CW:0]            net;
    logic                   overflow;

    assign sync_out   = sync_q[SYNC_STAGES-1];
    assign ready_o    = (credit_cnt_o != '0);
    assign tok_edge   = (state == ST_RUN) && (sync_out ^ edge_reg);
    assign ret        = tok_edge ? RET_VAL : '0;
    assign use_credit = send_v_i & ready_o;
    assign underflow  = send_v_i & ~ready_o;
    // Net is one bit wider than the counter so a return plus a full pool
    // cannot wrap before the saturation check.
    assign net        = {1'b0, credit_cnt_o} + ret - {{CW{1'b0}}, use_credit};
    assign overflow   = (net > MAX_WIDE);

    // Token synchroniser: shift io_token_i through SYNC_STAGES flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], io_token_i};
        end
    end

    // Prime/run sequencing and edge-detect register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_PRIME;
            prime_cnt <= '0;
            edge_reg  <= 1'b0;
        end else begin
            edge_reg <= sync_out;
            if (state == ST_PRIME) begin
                if (prime_cnt == PRIME_LAST) begin
                    state <= ST_RUN;
                end else begin
                    prime_cnt <= prime_cnt + 1'b1;
                end
            end
        end
    end

    // Credit pool, word/return counters and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_cnt_o <= MAX_CRED;
            sent_cnt_o   <= '0;
            finish_cnt_o <= '0;
            err_o        <= 1'b0;
        end else begin
            credit_cnt_o <= overflow ? MAX_CRED : net[CW-1:0];
            sent_cnt_o   <= sent_cnt_o + {{(CNT_W-1){1'b0}}, use_credit};
            finish_cnt_o <= finish_cnt_o + CNT_W'(ret);
            if (underflow || overflow) begin
                err_o <= 1'b1;
            end
        end
    end

`ifdef LINK_CREDIT_STALL_STATS_EN
    logic [CW-1:0] outstanding;
    assign outstanding = MAX_CRED - credit_cnt_o;

    // Stall cycle counter (saturating) and outstanding-credit high-water mark.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o       <= '0;
            max_outstanding_o <= '0;
        end else begin
            if ((state == ST_RUN) && !ready_o && (stall_cnt_o != 16'hFFFF)) begin
                stall_cnt_o <= stall_cnt_o + 16'd1;
            end
            if (outstanding > max_outstanding_o) begin
                max_outstanding_o <= outstanding;
            end
        end
    end
`endif

endmodule

// File: tb/tb_link_token_credit_ctr.sv
// Directed bench for link_token_credit_ctr at default parameters
// (CREDIT_MAX=32, LG_DECIM=3, SYNC_STAGES=2, CNT_W=7).
module tb_link_token_credit_ctr;

    logic       clk;
    logic       rst;
    logic       io_token_i;
    logic       send_v_i;
    logic       ready_o;
    logic [5:0] credit_cnt_o;
    logic [6:0] sent_cnt_o;
    logic [6:0] finish_cnt_o;
    logic       err_o;
`ifdef LINK_CREDIT_STALL_STATS_EN
    logic [15:0] stall_cnt_o;
    logic [5:0]  max_outstanding_o;
`endif

    int tests_run;
    int tests_failed;

    link_token_credit_ctr dut (
        .clk               (clk),
        .rst               (rst),
        .io_token_i        (io_token_i),
        .send_v_i          (send_v_i),
        .ready_o           (ready_o),
        .credit_cnt_o      (credit_cnt_o),
        .sent_cnt_o        (sent_cnt_o),
        .finish_cnt_o      (finish_cnt_o),
`ifdef LINK_CREDIT_STALL_STATS_EN
        .stall_cnt_o       (stall_cnt_o),
        .max_outstanding_o (max_outstanding_o),
`endif
        .err_o             (err_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; inputs are driven and outputs sampled 1 time unit after each edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hold send_v_i for n cycles, then drop it.
    task automatic send_words(input int n);
        send_v_i = 1'b1;
        tick(n);
        send_v_i = 1'b0;
    endtask

    // Reset for n cycles, release, then wait out PRIME with margin.
    task automatic do_reset(input int n);
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
        tick(6);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        io_token_i   = 1'b1;
        send_v_i     = 1'b0;

        // T1: reset with token high
        tick(3);
        chk("rst_ready",  32'(ready_o), 32'd1);
        chk("rst_credit", 32'(credit_cnt_o), 32'd32);
        chk("rst_sent",   32'(sent_cnt_o), 32'd0);
        chk("rst_finish", 32'(finish_cnt_o), 32'd0);
        chk("rst_err",    32'(err_o), 32'd0);
        rst = 1'b0;
        tick(6);
        chk("prime_no_edge_credit", 32'(credit_cnt_o), 32'd32);
        chk("prime_no_edge_finish", 32'(finish_cnt_o), 32'd0);

        // T2: drain the full pool
        send_words(32);
        chk("drain_credit", 32'(credit_cnt_o), 32'd0);
        chk("drain_ready",  32'(ready_o), 32'd0);
        chk("drain_sent",   32'(sent_cnt_o), 32'd32);
        chk("drain_err",    32'(err_o), 32'd0);

        // T3: one falling token edge from empty; 3-edge latency
        io_token_i = 1'b0;
        tick(2);
        chk("ret_latency_credit", 32'(credit_cnt_o), 32'd0);
        tick(1);
        chk("ret_credit", 32'(credit_cnt_o), 32'd8);
        chk("ret_finish", 32'(finish_cnt_o), 32'd8);
        chk("ret_ready",  32'(ready_o), 32'd1);

        // T4: credit 5, rising edge reaches counter in the same cycle as a send
        send_words(3);
        chk("sim_pre_credit", 32'(credit_cnt_o), 32'd5);
        io_token_i = 1'b1;
        tick(2);
        send_v_i = 1'b1;
        tick(1);
        send_v_i = 1'b0;
        chk("sim_credit", 32'(credit_cnt_o), 32'd12);
        chk("sim_sent",   32'(sent_cnt_o), 32'd36);
        chk("sim_finish", 32'(finish_cnt_o), 32'd16);

        // T5a: underflow
        send_words(12);
        chk("uf_pre_credit", 32'(credit_cnt_o), 32'd0);
        chk("uf_pre_err",    32'(err_o), 32'd0);
        send_words(1);
        chk("uf_credit", 32'(credit_cnt_o), 32'd0);
        chk("uf_sent",   32'(sent_cnt_o), 32'd48);
        chk("uf_err",    32'(err_o), 32'd1);

        // T5b: overflow from a full pool (token currently high)
        do_reset(2);
        chk("of_rst_err",    32'(err_o), 32'd0);
        chk("of_rst_credit", 32'(credit_cnt_o), 32'd32);
        io_token_i = 1'b0;
        tick(3);
        chk("of_credit", 32'(credit_cnt_o), 32'd32);
        chk("of_finish", 32'(finish_cnt_o), 32'd8);
        chk("of_err",    32'(err_o), 32'd1);

        // T6: 130 sends with a token edge every 8 sends (16 edges)
        do_reset(2);
        for (int i = 0; i < 130; i++) begin
            send_v_i = 1'b1;
            if ((i % 8) == 7) begin
                io_token_i = ~io_token_i;
            end
            tick(1);
        end
        send_v_i = 1'b0;
        tick(4);
        chk("wrap_sent",   32'(sent_cnt_o), 32'd2);
        chk("wrap_finish", 32'(finish_cnt_o), 32'd0);
        chk("wrap_credit", 32'(credit_cnt_o), 32'd30);
        chk("wrap_err",    32'(err_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
